// File: rtl/hazard_fwd_unit.sv
// Data-hazard controller for the 5-stage pipeline: tracks producer records through EX/MEM/WB,
// generates EX operand-mux selects, the load-use stall, the branch flush and a stall counter.
module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_count
);

    logic              ex_valid, ex_regwrite, ex_memread, ex_uses_rs1, ex_uses_rs2;
    logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2;
    logic              mem_valid, mem_regwrite, mem_memread;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_valid, wb_regwrite;
    logic [REG_AW-1:0] wb_rd;

    logic ex_load;
    logic rs1_hit, rs2_hit;
    logic mem_fwd_ok, wb_fwd_ok;

    assign ex_load = id_valid && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_uses_rs1  <= 1'b0;
            ex_uses_rs2  <= 1'b0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_rd       <= '0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= '0;
        end else begin
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_rd        <= mem_rd;
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            mem_rd       <= ex_rd;
            if (ex_load) begin
                ex_valid    <= 1'b1;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
                ex_uses_rs1 <= id_uses_rs1;
                ex_uses_rs2 <= id_uses_rs2;
                ex_rd       <= id_rd;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
            end else begin
                // bubble: no write, no load, so it can never look like a producer
                ex_valid    <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_uses_rs1 <= 1'b0;
                ex_uses_rs2 <= 1'b0;
                ex_rd       <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
            end
        end
    end

    assign flush   = ex_branch_taken && ex_valid;
    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    assign stall   = id_valid && !flush && ex_valid && ex_memread && ex_regwrite &&
                     (ex_rd != '0) && (rs1_hit || rs2_hit);

    // a load sitting in MEM has no ALU result to bypass, so it is excluded here
    assign mem_fwd_ok = mem_valid && mem_regwrite && !mem_memread && (mem_rd != '0);
    assign wb_fwd_ok  = wb_valid && wb_regwrite && (wb_rd != '0);

    always_comb begin
        fwd_a_sel = 2'd0;
        if (ex_valid && ex_uses_rs1) begin
            if (mem_fwd_ok && (mem_rd == ex_rs1))
                fwd_a_sel = 2'd1;
            else if (wb_fwd_ok && (wb_rd == ex_rs1))
                fwd_a_sel = 2'd2;
        end
    end

    always_comb begin
        fwd_b_sel = 2'd0;
        if (ex_valid && ex_uses_rs2) begin
            if (mem_fwd_ok && (mem_rd == ex_rs2))
                fwd_b_sel = 2'd1;
            else if (wb_fwd_ok && (wb_rd == ex_rs2))
                fwd_b_sel = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed table-driven bench for hazard_fwd_unit (CNT_W=4 so saturation is reachable).
module tb_hazard_fwd_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
    logic       ex_branch_taken;
    logic       stall, flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [3:0] stall_count;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       br;
        logic       e_st;
        logic       e_fl;
        logic [1:0] e_a;
        logic [1:0] e_b;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[29];

    hazard_fwd_unit #(.REG_AW(5), .CNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_valid(id_valid),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd),
        .id_regwrite(id_regwrite),
        .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken),
        .stall(stall),
        .flush(flush),
        .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, int rs1, int rs2, logic u1, logic u2, int rd,
                                logic rw, logic mr, logic br,
                                logic st, logic fl, int a, int b, int cnt);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = u1; r.u2 = u2;
        r.rd = 5'(rd); r.rw = rw; r.mr = mr; r.br = br;
        r.e_st = st; r.e_fl = fl; r.e_a = 2'(a); r.e_b = 2'(b); r.e_cnt = 4'(cnt);
        return r;
    endfunction

    task automatic check(string name, logic st, logic fl, logic [1:0] a, logic [1:0] b,
                         logic [3:0] cnt);
        n_vec++;
        if (stall !== st || flush !== fl || fwd_a_sel !== a || fwd_b_sel !== b ||
            stall_count !== cnt) begin
            n_bad++;
            $display("FAIL %s: got stall=%0b flush=%0b a=%0d b=%0d cnt=%0d, want stall=%0b flush=%0b a=%0d b=%0d cnt=%0d",
                     name, stall, flush, fwd_a_sel, fwd_b_sel, stall_count, st, fl, a, b, cnt);
        end
    endtask

    task automatic drive(vec_t t);
        id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2;
        id_uses_rs1 = t.u1; id_uses_rs2 = t.u2; id_rd = t.rd;
        id_regwrite = t.rw; id_memread = t.mr; ex_branch_taken = t.br;
    endtask

    task automatic apply(string name, vec_t t);
        @(negedge clk);
        drive(t);
        #1;
        check(name, t.e_st, t.e_fl, t.e_a, t.e_b, t.e_cnt);
    endtask

    initial begin
        int exp_cnt;
        n_vec = 0;
        n_bad = 0;

        //             v  rs1 rs2 u1 u2 rd rw mr br | st fl a  b cnt
        tbl[0]  = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1,  2,  1, 1, 5, 1, 0, 0,   0, 0, 0, 0, 0);  // add x5
        tbl[2]  = mk(1, 5,  5,  1, 1, 6, 1, 0, 0,   0, 0, 0, 0, 0);  // sub x6,x5,x5
        tbl[3]  = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0);
        tbl[4]  = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1,  2,  1, 1, 7, 1, 0, 0,   0, 0, 0, 0, 0);  // add x7
        tbl[6]  = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 1,  7,  1, 1, 8, 1, 0, 0,   0, 0, 0, 0, 0);  // or x8,x1,x7
        tbl[8]  = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0);
        tbl[9]  = mk(1, 1,  2,  1, 1, 7, 1, 0, 0,   0, 0, 0, 0, 0);  // add x7
        tbl[10] = mk(1, 1,  2,  1, 1, 7, 1, 0, 0,   0, 0, 0, 0, 0);  // add x7
        tbl[11] = mk(1, 7,  3,  1, 1, 9, 1, 0, 0,   0, 0, 0, 0, 0);  // or x9,x7,x3
        tbl[12] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
        tbl[13] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        tbl[14] = mk(1, 1,  0,  1, 0, 3, 1, 1, 0,   0, 0, 0, 0, 0);  // lw x3
        tbl[15] = mk(1, 3,  2,  1, 1, 4, 1, 0, 0,   1, 0, 0, 0, 0);  // add x4,x3,x2
        tbl[16] = mk(1, 3,  2,  1, 1, 4, 1, 0, 0,   0, 0, 0, 0, 1);  // held add
        tbl[17] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 1);
        tbl[18] = mk(1, 1,  0,  1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1);  // addi x0
        tbl[19] = mk(1, 0,  2,  1, 1, 10,1, 0, 0,   0, 0, 0, 0, 1);  // add x10,x0,x2
        tbl[20] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
        tbl[21] = mk(1, 1,  0,  1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1);  // lw x0
        tbl[22] = mk(1, 0,  0,  1, 0, 11,1, 0, 0,   0, 0, 0, 0, 1);  // add x11,x0
        tbl[23] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
        tbl[24] = mk(1, 1,  0,  1, 0, 12,1, 1, 0,   0, 0, 0, 0, 1);  // lw x12
        tbl[25] = mk(1, 12, 0,  1, 0, 14,1, 1, 1,   0, 1, 0, 0, 1);  // lw x14,(x12) + redirect
        tbl[26] = mk(1, 14, 0,  1, 0, 15,1, 0, 0,   0, 0, 0, 0, 1);  // add x15,x14
        tbl[27] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
        tbl[28] = mk(0, 0,  0,  0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1);  // redirect, EX empty

        rst_n = 1'b0;
        drive(tbl[0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            id_valid = 1'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
            id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom); id_rd = 5'($urandom);
            id_regwrite = 1'($urandom); id_memread = 1'($urandom);
            ex_branch_taken = 1'($urandom);
            #1;
            check($sformatf("reset%0d", i), 1'b0, 1'b0, 2'd0, 2'd0, 4'd0);
        end
        @(negedge clk);
        drive(tbl[0]);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // repeated load-use pairs drive the 4-bit counter into saturation
        exp_cnt = 1;
        for (int i = 0; i < 15; i++) begin
            apply($sformatf("sat_lw%0d", i),  mk(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, exp_cnt));
            apply($sformatf("sat_use%0d", i), mk(1, 3, 2, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0, exp_cnt));
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            apply($sformatf("sat_hold%0d", i), mk(1, 3, 2, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, exp_cnt));
            apply($sformatf("sat_fwd%0d", i),  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, exp_cnt));
        end

        // asynchronous reset in the middle of a stall, then of a flush, before any edge
        apply("rst_lw", mk(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 15));
        @(negedge clk);
        drive(mk(1, 3, 2, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("rst_stall_on", 1'b1, 1'b0, 2'd0, 2'd0, 4'd15);
        #1 ex_branch_taken = 1'b1;
        #1;
        check("rst_flush_on", 1'b0, 1'b1, 2'd0, 2'd0, 4'd15);
        #1 rst_n = 1'b0;
        #0.5;
        check("rst_async", 1'b0, 1'b0, 2'd0, 2'd0, 4'd0);
        @(negedge clk);
        drive(tbl[0]);
        rst_n = 1'b1;
        apply("rst_after", tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Data-hazard controller for the 5-stage pipeline.
- Tracks the destination register, write-enable and load flag of each instruction as it moves from ID through EX, MEM and WB.
- Drives the 2-bit select inputs of the two EX-stage 4:1 operand muxes, the load-use stall, and the branch flush.
- Sits beside the ID/EX pipeline register. It is the producer of the operand-mux select codes.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 32, stall performance-counter width.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ID_VALID  in  1  ID stage holds a real instruction.
- ID_RS1  in  REG_AW  source register 1 index.
- ID_RS2  in  REG_AW  source register 2 index.
- ID_USES_RS1  in  1  instruction reads rs1.
- ID_USES_RS2  in  1  instruction reads rs2.
- ID_RD  in  REG_AW  destination register index.
- ID_REGWRITE  in  1  instruction writes rd.
- ID_MEMREAD  in  1  instruction is a load.
- EX_BRANCH_TAKEN  in  1  EX-stage branch/jump redirect.
- STALL  out  1  hold PC and IF/ID; insert bubble into EX.
- FLUSH  out  1  kill IF/ID contents.
- FWD_A_SEL  out  2  operand-A mux select for the EX instruction.
- FWD_B_SEL  out  2  operand-B mux select for the EX instruction.
- STALL_COUNT  out  CNT_W  number of stall cycles.

Behaviour:
- Clock and reset: single clock CLK. Reset RST_N is asynchronous and active-low.
- Reset state: all stage records invalid, fields zero. STALL=0, FLUSH=0, FWD_A_SEL=0, FWD_B_SEL=0, STALL_COUNT=0.
- Stage records: EX, MEM and WB each hold {valid, rd, regwrite, memread}. The EX record also holds {rs1, rs2, uses_rs1, uses_rs2}.
- Record advance, every rising CLK edge:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields when ID_VALID & !STALL & !FLUSH; otherwise EX <= bubble (valid=0).
- Record effects:
  - A bubble has regwrite=0 and memread=0.
  - A record with rd==0 never matches as a producer.
- STALL (combinational) = ID_VALID & !FLUSH & EX.valid & EX.memread & EX.regwrite & EX.rd!=0 & ((ID_USES_RS1 & ID_RS1==EX.rd) | (ID_USES_RS2 & ID_RS2==EX.rd)).
  - Stall lasts exactly one cycle per load-use pair, because the load moves to MEM and the bubble occupies EX.
- FLUSH (combinational) = EX_BRANCH_TAKEN & EX.valid.
  - FLUSH has priority over STALL: STALL is forced to 0 while FLUSH=1.
- Forwarding select codes (combinational from registered records only, no input-to-output path):
  - 0 = register file.
  - 1 = EX/MEM ALU result.
  - 2 = MEM/WB writeback data.
  - 3 = reserved, never driven.
- FWD_A_SEL:
  - 1 when EX.valid & EX.uses_rs1 & MEM.valid & MEM.regwrite & !MEM.memread & MEM.rd!=0 & MEM.rd==EX.rs1.
  - Else 2 when EX.valid & EX.uses_rs1 & WB.valid & WB.regwrite & WB.rd!=0 & WB.rd==EX.rs1.
  - Else 0.
  - MEM wins over WB, giving the youngest producer.
- FWD_B_SEL: identical rule using rs2.
- Load in MEM matching an EX source: cannot occur because of the stall. If it occurs anyway, the select falls to the WB check or 0. No assertion is raised in RTL.
- Register-file write in the WB stage: the register file is write-through, so no third bypass level exists.
- STALL_COUNT: increments by 1 on each edge where STALL=1. Saturates at all-ones and never wraps.
- RST_N asserted mid-stall or mid-flush: all outputs drop to reset values immediately, without waiting for CLK.

Test Plan:
- Reset: hold RST_N=0 with random inputs → STALL=0, FLUSH=0, sels=0, STALL_COUNT=0. Deassert → same until an instruction enters.
- EX-to-EX forward: add x5 (rd=5, regwrite), then next cycle sub with rs1=5, rs2=5 → when sub is in EX, FWD_A_SEL=1, FWD_B_SEL=1.
- MEM-to-EX forward and priority: add x7; nop; or rs2=7 → FWD_B_SEL=2 and FWD_A_SEL=0. Then add x7; add x7; or rs1=7 → FWD_A_SEL=1.
- Load-use: lw x3; add rs1=3 → STALL=1 for exactly one cycle and STALL_COUNT 0→1. After the stall, add in EX has FWD_A_SEL=2.
- x0 and flush: addi x0; add rs1=0 → sels=0, no stall. Branch in EX with EX_BRANCH_TAKEN=1 while ID holds a load-use consumer → FLUSH=1, STALL=0, next EX record is a bubble, STALL_COUNT unchanged.
- Saturation and asynchronous reset: force STALL_COUNT to all-ones with CNT_W=4 → stays 15 on a further stall. Pulse RST_N low mid-stall → outputs clear before the next CLK edge.
